// File: rtl/mem_request_unit.sv
// Single-port memory request unit: arbitrates store > load > fetch onto one bus.
// Optional bus-wait timeout is compiled in with `define MEM_REQ_TIMEOUT_EN.
module mem_request_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] pc,
  input  logic        data_read_req,
  input  logic        data_write_req,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [31:0] data_in_BUS,
  input  logic        bus_full,
  output logic [31:0] address_out,
  output logic [31:0] data_out_BUS,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] data_cpu_o,
  output logic        data_valid,
  output logic        instr_wait,
  output logic        bus_error
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] STORE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] data_q, data_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        ivalid_q, ivalid_d;
  logic        dvalid_q, dvalid_d;
  logic        tmo_s;
  logic        done_s;
  logic [31:0] word_s;

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Completion on bus acknowledge; a timed-out access completes with a zero word
  always_comb begin
    tmo_s = 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
    if (!bus_full && (cnt_q == CNT_LAST)) begin
      tmo_s = 1'b1;
    end else begin
      tmo_s = 1'b0;
    end
`endif
    done_s = bus_full | tmo_s;
    word_s = tmo_s ? 32'h0000_0000 : data_in_BUS;
  end

  // Request arbitration, bus strobes and result capture
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    instr_d  = instr_q;
    data_d   = data_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    ivalid_d = 1'b0;
    dvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_write_req) begin
          state_d = STORE;
          addr_d  = data_addr;
          wdata_d = data_wdata;
          rd_d    = 1'b0;
          wr_d    = 1'b1;
        end else if (data_read_req) begin
          state_d = LOAD;
          addr_d  = data_addr;
          rd_d    = 1'b1;
          wr_d    = 1'b0;
        end else if (fetch_req) begin
          state_d = FETCH;
          addr_d  = pc;
          rd_d    = 1'b1;
          wr_d    = 1'b0;
        end else begin
          rd_d = 1'b0;
          wr_d = 1'b0;
        end
      end
      FETCH, LOAD, STORE: begin
        if (done_s) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (state_q == FETCH) begin
            instr_d  = word_s;
            ivalid_d = 1'b1;
          end else if (state_q == LOAD) begin
            data_d   = word_s;
            dvalid_d = 1'b1;
          end else begin
            dvalid_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // Main state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= 32'h0000_0000;
      wdata_q  <= 32'h0000_0000;
      instr_q  <= 32'h0000_0000;
      data_q   <= 32'h0000_0000;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ivalid_q <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      instr_q  <= instr_d;
      data_q   <= data_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ivalid_q <= ivalid_d;
      dvalid_q <= dvalid_d;
    end
  end

`ifdef MEM_REQ_TIMEOUT_EN
  // Wait counter restarts on every entry to a bus state; the error flag is sticky
  always_comb begin
    if ((state_q == IDLE) || done_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if ((state_q != IDLE) && tmo_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Timeout counter and error flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus_error = err_q;
`else
  assign bus_error = 1'b0;
`endif

  assign address_out  = addr_q;
  assign data_out_BUS = wdata_q;
  assign bus_read     = rd_q;
  assign bus_write    = wr_q;
  assign instr_out    = instr_q;
  assign instr_valid  = ivalid_q;
  assign data_cpu_o   = data_q;
  assign data_valid   = dvalid_q;
  assign instr_wait   = (state_q != IDLE) | fetch_req | data_read_req | data_write_req;

endmodule

// File: tb/tb_mem_request_unit.sv
// Scoreboard bench for mem_request_unit: a driver issues transactions and queues the
// expected bus access and result; a monitor checks strobes, results and held outputs.
module tb_mem_request_unit;
  localparam int TO = 16;
  localparam logic [1:0] K_FETCH = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        fetch_req = 1'b0, data_read_req = 1'b0, data_write_req = 1'b0;
  logic [31:0] pc = 32'h0, data_addr = 32'h0, data_wdata = 32'h0;
  logic [31:0] data_in_BUS;
  logic        bus_full;
  logic [31:0] address_out, data_out_BUS, instr_out, data_cpu_o;
  logic        bus_read, bus_write, instr_valid, data_valid, instr_wait, bus_error;

  mem_request_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc(pc),
    .data_read_req(data_read_req), .data_write_req(data_write_req),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_in_BUS(data_in_BUS),
    .bus_full(bus_full), .address_out(address_out), .data_out_BUS(data_out_BUS),
    .bus_read(bus_read), .bus_write(bus_write), .instr_out(instr_out),
    .instr_valid(instr_valid), .data_cpu_o(data_cpu_o), .data_valid(data_valid),
    .instr_wait(instr_wait), .bus_error(bus_error)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] result;
    logic        tmo;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model_instr = 32'h0;
  logic [31:0] model_data = 32'h0;
  logic        model_err = 1'b0;
  bit          checking = 1'b0;
  int          resp_lat = 0;
  logic [31:0] resp_data = 32'h0;
  int          wait_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic set_reqs(input logic [2:0] wrf);
    {data_write_req, data_read_req, fetch_req} = wrf;
  endtask

  task automatic clear_model();
    exp_q.delete();
    model_instr = 32'h0;
    model_data  = 32'h0;
    model_err   = 1'b0;
  endtask

  // Bus slave: acknowledges after resp_lat strobe cycles, random noise when idle
  initial begin
    bus_full    = 1'b0;
    data_in_BUS = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (bus_read || bus_write) begin
        if (wait_cnt == resp_lat) begin
          bus_full    = 1'b1;
          data_in_BUS = resp_data;
        end else begin
          bus_full    = 1'b0;
          data_in_BUS = $urandom;
        end
        wait_cnt++;
      end else begin
        wait_cnt    = 0;
        bus_full    = 1'($urandom_range(0, 1));
        data_in_BUS = $urandom;
      end
    end
  end

  // Monitor: compares every observed bus access and completion to the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (checking && !rst) begin
      if (bus_read || bus_write) begin
        if (exp_q.size() == 0) begin
          chk("strobe_unexpected", {30'h0, bus_write, bus_read}, 32'h0);
        end else begin
          e = exp_q[0];
          chk("strobe_kind", {30'h0, bus_write, bus_read},
              (e.kind == K_STORE) ? 32'h2 : 32'h1);
          chk("address_out", address_out, e.addr);
          if (e.kind == K_STORE) chk("data_out_BUS", data_out_BUS, e.wdata);
        end
      end
      if (instr_valid || data_valid) begin
        chk("strobes_after_done", {30'h0, bus_write, bus_read}, 32'h0);
        if (exp_q.size() == 0) begin
          chk("valid_unexpected", {30'h0, instr_valid, data_valid}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("valid_kind", {30'h0, instr_valid, data_valid},
              (e.kind == K_FETCH) ? 32'h2 : 32'h1);
          if (e.tmo) model_err = 1'b1;
          if (e.kind == K_FETCH) model_instr = e.result;
          if (e.kind == K_LOAD) model_data = e.result;
        end
      end
      chk("instr_out", instr_out, model_instr);
      chk("data_cpu_o", data_cpu_o, model_data);
      chk("bus_error", {31'h0, bus_error}, {31'h0, model_err});
      chk("instr_wait", {31'h0, instr_wait},
          {31'h0, bus_read | bus_write | fetch_req | data_read_req | data_write_req});
    end
  end

  // Issue one round of requests; the winner follows store > load > fetch
  task automatic issue(input logic [2:0] wrf, input logic [31:0] a_pc, input logic [31:0] a_addr,
                       input logic [31:0] a_wdata, input int lat, input logic [31:0] rdata,
                       input logic tmo, input int exp_cyc);
    exp_t e;
    int   cyc;
    bit   got;
    pc = a_pc; data_addr = a_addr; data_wdata = a_wdata;
    resp_lat = lat; resp_data = rdata;
    set_reqs(wrf);
    e.tmo    = tmo;
    e.wdata  = a_wdata;
    e.result = tmo ? 32'h0 : rdata;
    if (wrf[2]) begin
      e.kind = K_STORE; e.addr = a_addr;
    end else if (wrf[1]) begin
      e.kind = K_LOAD;  e.addr = a_addr;
    end else begin
      e.kind = K_FETCH; e.addr = a_pc;
    end
    exp_q.push_back(e);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (instr_valid || data_valid) begin
        got = 1'b1;
      end else begin
        pc = $urandom; data_addr = $urandom; data_wdata = $urandom;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL valid_timeout: no valid pulse after %0d cycles, required one", cyc);
      rst = 1'b1; set_reqs(3'b000); clear_model();
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      chk("latency", cyc, exp_cyc);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_address_out", address_out, 32'h0);
    chk("rst_data_out_BUS", data_out_BUS, 32'h0);
    chk("rst_instr_out", instr_out, 32'h0);
    chk("rst_data_cpu_o", data_cpu_o, 32'h0);
    chk("rst_flags", {26'h0, bus_read, bus_write, instr_valid, data_valid, bus_error, instr_wait}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    checking = 1'b1;

    // Directed fetch, load, and store-with-pending-fetch (back-to-back)
    issue(3'b001, 32'h100, 32'h0, 32'h0, 1, 32'h00308083, 1'b0, 3);
    set_reqs(3'b000);
    repeat (2) @(posedge clk); #1;
    issue(3'b010, 32'h0, 32'h7, 32'h0, 2, 32'h1, 1'b0, 4);
    set_reqs(3'b000);
    @(posedge clk); #1;
    issue(3'b101, 32'h300, 32'h20, 32'hDEADBEEF, 0, 32'h0, 1'b0, 2);
    issue(3'b001, 32'h300, 32'h0, 32'h0, 3, 32'h12345678, 1'b0, 5);
    set_reqs(3'b000);
    @(posedge clk); #1;

    // Reset two cycles into a load wait, with the request still high
    pc = 32'h0; data_addr = 32'h44; resp_lat = 100000;
    set_reqs(3'b010);
    exp_q.push_back('{kind: K_LOAD, addr: 32'h44, wdata: 32'h0, result: 32'h0, tmo: 1'b0});
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_reqs(3'b000);
    clear_model();
    @(negedge clk);
    chk("rst_mid_bus_read", {31'h0, bus_read}, 32'h0);
    chk("rst_mid_data_valid", {31'h0, data_valid}, 32'h0);
    chk("rst_mid_data_cpu_o", data_cpu_o, 32'h0);
    @(posedge clk); #1;

    // Randomized rounds with random overlap, latency and back-to-back issue
    for (int i = 0; i < 80; i++) begin
      logic [2:0] wrf;
      int         lat;
      wrf = 3'($urandom_range(1, 7));
      lat = $urandom_range(0, 6);
      issue(wrf, $urandom, $urandom, $urandom, lat, $urandom, 1'b0, lat + 2);
      if ($urandom_range(0, 2) != 0) begin
        set_reqs(3'b000);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    set_reqs(3'b000);
    @(posedge clk); #1;

`ifdef MEM_REQ_TIMEOUT_EN
    issue(3'b001, 32'h500, 32'h0, 32'h0, 100000, 32'hFFFF_FFFF, 1'b1, TO + 1);
    set_reqs(3'b000);
    repeat (4) @(posedge clk); #1;
    issue(3'b010, 32'h0, 32'h60, 32'h0, 1, 32'hCAFE_F00D, 1'b0, 3);
    set_reqs(3'b000);
    repeat (2) @(posedge clk); #1;
`else
    pc = 32'h500; resp_lat = 100000;
    set_reqs(3'b001);
    exp_q.push_back('{kind: K_FETCH, addr: 32'h500, wdata: 32'h0, result: 32'h0, tmo: 1'b0});
    repeat (100) @(posedge clk); #1;
    set_reqs(3'b000);
    @(negedge clk);
    chk("still_waiting", {29'h0, bus_read, instr_valid, bus_error}, 32'h4);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    repeat (2) @(posedge clk); #1;
`endif

    if (exp_q.size() != 0) chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_request_unit.md
MEM_REQUEST_UNIT -- requirements
Module: mem_request_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, which sets the bus wait limit in cycles and is used only when the timeout feature is compiled in.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port fetch_req, input, 1 bit: the core requests the instruction at pc.
REQ-005 The block SHALL have port pc, input, 32 bits: the instruction fetch address.
REQ-006 The block SHALL have port data_read_req, input, 1 bit: the core requests a load from data_addr.
REQ-007 The block SHALL have port data_write_req, input, 1 bit: the core requests a store of data_wdata to data_addr.
REQ-008 The block SHALL have port data_addr, input, 32 bits: the load/store address.
REQ-009 The block SHALL have port data_wdata, input, 32 bits: the store data.
REQ-010 The block SHALL have port data_in_BUS, input, 32 bits: read data from the memory bus.
REQ-011 The block SHALL have port bus_full, input, 1 bit: bus acknowledge; data_in_BUS is valid, or the write is accepted, when it is high.
REQ-012 The block SHALL have port address_out, output, 32 bits: the bus address.
REQ-013 The block SHALL have port data_out_BUS, output, 32 bits: the bus write data.
REQ-014 The block SHALL have port bus_read, output, 1 bit: bus read strobe.
REQ-015 The block SHALL have port bus_write, output, 1 bit: bus write strobe.
REQ-016 The block SHALL have port instr_out, output, 32 bits: the last fetched instruction.
REQ-017 The block SHALL have port instr_valid, output, 1 bit: one-cycle pulse indicating instr_out has been updated.
REQ-018 The block SHALL have port data_cpu_o, output, 32 bits: the last loaded data word.
REQ-019 The block SHALL have port data_valid, output, 1 bit: one-cycle pulse at the completion of a load or store.
REQ-020 The block SHALL have port instr_wait, output, 1 bit: core stall.
REQ-021 The block SHALL have port bus_error, output, 1 bit: sticky timeout flag.

Function
REQ-022 The block SHALL implement the FSM states IDLE, FETCH, LOAD and STORE, all registered.
REQ-023 In IDLE, at each rising edge, the block SHALL arbitrate pending requests with priority data_write_req > data_read_req > fetch_req, moving to STORE, LOAD or FETCH respectively and capturing the address (and data_wdata for a store) into registers.
REQ-024 In the first cycle after leaving IDLE, address_out SHALL be driven from the captured register, and exactly one of bus_read (FETCH/LOAD) or bus_write (STORE) SHALL be high; it SHALL be held stable until completion.
REQ-025 Completion SHALL occur at the first rising edge in FETCH, LOAD or STORE at which bus_full=1, with minimum latency of 2 cycles from the request edge to the valid pulse.
REQ-026 At completion of a FETCH, data_in_BUS SHALL be captured into instr_out, instr_valid SHALL be high for the next cycle only, and the FSM SHALL return to IDLE.
REQ-027 At completion of a LOAD, data_in_BUS SHALL be captured into data_cpu_o, data_valid SHALL be high for the next cycle only, and the FSM SHALL return to IDLE.
REQ-028 At completion of a STORE, data_cpu_o SHALL remain unchanged, data_valid SHALL pulse for one cycle, and the FSM SHALL return to IDLE.
REQ-029 bus_read and bus_write SHALL be 0 in the cycle following completion.
REQ-030 instr_wait SHALL equal (state != IDLE) OR (state == IDLE AND any request input high), computed combinationally.
REQ-031 The core SHALL hold its request inputs until the matching valid pulse; a request that is still high during the valid cycle SHALL be treated as a new request.
REQ-032 bus_full while in IDLE SHALL be ignored, with no state or output change.
REQ-033 Request inputs that change while the FSM is not in IDLE SHALL be ignored; the captured address and data SHALL be used.
REQ-034 Back-to-back requests SHALL be supported: a request high in a valid cycle SHALL start the next transaction on that edge.
REQ-035 instr_out and data_cpu_o SHALL hold their values between completions.

Reset
REQ-036 With rst=1 at a rising edge, the next state SHALL be IDLE, and address_out, data_out_BUS, instr_out and data_cpu_o SHALL be 32'h0.
REQ-037 With rst=1 at a rising edge, bus_read, bus_write, instr_valid, data_valid and bus_error SHALL be 0, and the timeout counter SHALL be 0.
REQ-038 Reset asserted mid-transaction SHALL abort it without a valid pulse, and the strobes SHALL be low in the cycle after the reset edge.
REQ-039 Reset SHALL take priority over bus_full and over all requests in the same cycle.

Configuration
REQ-040 When macro MEM_REQ_TIMEOUT_EN is defined, a counter SHALL increment each cycle spent in FETCH, LOAD or STORE without bus_full and SHALL clear on entry to any of those states.
REQ-041 When MEM_REQ_TIMEOUT_EN is defined and the count reaches TIMEOUT_CYCLES-1 with bus_full=0, the block SHALL return to IDLE, pulse the matching valid output with the destination register loaded with 32'h0 (stores: none), and set bus_error=1 until reset.
REQ-042 When MEM_REQ_TIMEOUT_EN is defined and bus_full=1 in the same cycle the timeout is reached, the cycle SHALL be a normal completion.
REQ-043 When MEM_REQ_TIMEOUT_EN is not defined, the block SHALL wait indefinitely, no counter SHALL exist, and bus_error SHALL be tied to 0 with the port retained.

Verification
REQ-044 Fetch: pc=32'h100, fetch_req=1, bus_full=1 on the 3rd cycle with data_in_BUS=32'h00308083 -> address_out=32'h100, bus_read=1, then instr_out=32'h00308083, instr_valid pulses once, and instr_wait is low after the pulse.
REQ-045 Load then add flow: data_read_req with data_addr=32'h7, data_in_BUS=32'h1 -> data_cpu_o=32'h1, data_valid pulses once, and bus_write stays 0 throughout.
REQ-046 Store: data_write_req with data_addr=32'h20, data_wdata=32'hDEADBEEF, and fetch_req high simultaneously -> STORE is issued first with data_out_BUS=32'hDEADBEEF and bus_write=1, then FETCH.
REQ-047 Reset mid-LOAD: rst=1 two cycles into the wait -> bus_read=0 next cycle, no data_valid, and data_cpu_o=32'h0.
REQ-048 Timeout (macro defined, TIMEOUT_CYCLES=16): FETCH with bus_full held 0 -> return to IDLE after 16 wait cycles, instr_valid pulses, instr_out=32'h0, and bus_error=1 sticky; without the macro -> still waiting at 100 cycles.
